// File: rtl/regfile_read_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared types and constants for the register-file read-port arbiter.
//   REG_AW / REG_DW : register index and data widths of the 32x64 register file
//   XZR_IDX         : index 31, the architectural zero register
//   reg_addr_t      : register index type
//   reg_data_t      : register data type
//   rsp_state_e     : response-slot state (EMPTY / FULL)
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int REG_AW = 5;
   localparam int REG_DW = 64;

   localparam logic [REG_AW-1:0] XZR_IDX = 5'd31;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [REG_DW-1:0] reg_data_t;

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_read_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_read_arbiter_if
//   Requester/consumer bundle of the register-file read arbiter.
//   req_valid  : per-requester read request
//   req_addr   : per-requester register index, requester i at [i*AW +: AW]
//   req_ready  : one-hot grant
//   rsp_valid  : response slot holds data
//   rsp_id     : requester index owning the response
//   rsp_data   : read data
//   rsp_ready  : consumer accepts the response
//
//   Handshake: a transfer happens on a rising clock edge where valid and ready
//   are both high. A requester keeps valid high and its address stable until
//   accepted; dropping valid early only forfeits its turn. The response slot
//   keeps rsp_id/rsp_data stable while rsp_valid is high and rsp_ready is low.
//
//   Modports: slave = arbiter side, master = requester/consumer side.
// -----------------------------------------------------------------------------
interface regfile_read_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DW      = 64,
   parameter int AW      = 5
);

   localparam int IW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*AW-1:0] req_addr;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  rsp_valid;
   logic [IW-1:0]         rsp_id;
   logic [DW-1:0]         rsp_data;
   logic                  rsp_ready;

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data
   );

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data
   );

endinterface : regfile_read_arbiter_if

// File: rtl/regfile_read_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick: the first set bit of req_i at or
//   after ptr_i, wrapping NUM_REQ-1 -> 0.
//   req_i      in   NUM_REQ  request vector
//   ptr_i      in   IW       highest-priority index this cycle
//   gnt_o      out  NUM_REQ  one-hot grant (zero when no request)
//   gnt_idx_o  out  IW       index of the granted requester (0 when none)
//   gnt_vld_o  out  1        some requester was granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IW-1:0]      gnt_idx_o,
   output logic               gnt_vld_o
);

   always_comb begin
      logic [IW-1:0] j;
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_vld_o = 1'b0;
      j         = '0;
      // Scan from the pointer outward; the first hit wins.
      for (int k = 0; k < NUM_REQ; k++) begin
         j = IW'((int'(ptr_i) + k) % NUM_REQ);
         if (!gnt_vld_o && req_i[j]) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = j;
            gnt_o[j]  = 1'b1;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/regfile_read_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_read_arbiter
//   Shares the single read port of the 32x64 register file between NUM_REQ
//   requesters: round-robin grant, one registered response slot with
//   backpressure, XZR (index 31) reads as zero.
//
//   Optional build macro RF_BYPASS_EN: when defined, a read that collides with
//   a same-cycle write to the same register returns the write data; when not
//   defined the old register value is returned and rf_wr_* are ignored.
//
//   Ports
//   clk           in   1        rising-edge clock
//   rst_n         in   1        asynchronous active-low reset
//   bus           slave modport of regfile_read_arbiter_if (req_*/rsp_*)
//   rf_rd_sel     out  AW       register-file read-mux select
//   rf_rd_data    in   DW       read-mux output for rf_rd_sel
//   rf_wr_en      in   1        register-file write strobe
//   rf_wr_addr    in   AW       register-file write index
//   rf_wr_data    in   DW       register-file write data
//   dbg_state_o   out  enum     response-slot state
//   dbg_rr_ptr_o  out  IW       round-robin pointer
// -----------------------------------------------------------------------------
module regfile_read_arbiter
   import regfile_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int DW      = REG_DW,
   parameter  int AW      = REG_AW,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   regfile_read_arbiter_if.slave        bus,
   output logic [AW-1:0]                rf_rd_sel,
   input  logic [DW-1:0]                rf_rd_data,
   input  logic                         rf_wr_en,
   input  logic [AW-1:0]                rf_wr_addr,
   input  logic [DW-1:0]                rf_wr_data,
   output rsp_state_e                   dbg_state_o,
   output logic [IW-1:0]                dbg_rr_ptr_o
);

   rsp_state_e    state_q,    state_d;
   logic [IW-1:0] rr_ptr_q,   rr_ptr_d;
   logic [DW-1:0] rsp_data_q, rsp_data_d;
   logic [IW-1:0] rsp_id_q,   rsp_id_d;

   logic [NUM_REQ-1:0] gnt;
   logic [IW-1:0]      gnt_idx;
   logic               gnt_vld;
   logic               stall;
   logic               accept;
   logic [DW-1:0]      rd_val;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_i     (bus.req_valid),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_vld_o (gnt_vld)
   );

   // A full slot that is not being drained blocks every grant. The grant is
   // also masked while reset is asserted so req_ready is low during reset.
   assign stall  = (state_q == RSP_FULL) && !bus.rsp_ready;
   assign accept = gnt_vld && !stall && rst_n;

   assign bus.req_ready = accept ? gnt : '0;
   assign rf_rd_sel     = accept ? bus.req_addr[gnt_idx*AW +: AW] : '0;

   // Read value: XZR wins over everything, then the optional write bypass.
   always_comb begin
      rd_val = rf_rd_data;
`ifdef RF_BYPASS_EN
      if (rf_wr_en && (rf_wr_addr == rf_rd_sel)) begin
         rd_val = rf_wr_data;
      end
`endif
      if (rf_rd_sel == XZR_IDX) begin
         rd_val = '0;
      end
   end

`ifndef RF_BYPASS_EN
   logic unused_wr;
   assign unused_wr = ^{rf_wr_en, rf_wr_addr, rf_wr_data};
`endif

   // Next state: an accept always (re)fills the slot; a drain without a new
   // accept only clears valid, leaving id/data at their last value.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      if (accept) begin
         state_d    = RSP_FULL;
         rsp_data_d = rd_val;
         rsp_id_d   = gnt_idx;
         rr_ptr_d   = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else if ((state_q == RSP_FULL) && bus.rsp_ready) begin
         state_d = RSP_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RSP_EMPTY;
         rr_ptr_q   <= '0;
         rsp_data_q <= '0;
         rsp_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
      end
   end

   assign bus.rsp_valid = (state_q == RSP_FULL);
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;

   assign dbg_state_o  = state_q;
   assign dbg_rr_ptr_o = rr_ptr_q;

endmodule : regfile_read_arbiter
